// File: rtl/iter_alu_if.sv
// Operand/result bundle between the issue stage and iter_alu.
// Optional multiply is controlled by ITER_ALU_MUL_EN inside iter_alu, not here.
// master drives start/a/b/sel; slave returns f/ovf/take_branch/busy/done.
interface iter_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic [WIDTH-1:0] f;
  logic             ovf;
  logic             take_branch;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, sel,
    input  f, ovf, take_branch, busy, done
  );

  modport slave (
    input  start, a, b, sel,
    output f, ovf, take_branch, busy, done
  );
endinterface

// File: rtl/iter_alu.sv
// Iterative WIDTH-bit ALU: ADD/NOT/AND/OR/SHR/SHL/EQ/NEQ/SUB, plus shift-add MUL when ITER_ALU_MUL_EN is defined.
// Latency start->done: 2 cycles for single-step ops, n+2 for shifts by n, WIDTH+2 for MUL.
// No backpressure: start is only sampled in IDLE; start while busy is dropped, done is a one-cycle pulse.
module iter_alu #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  iter_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;   // counter must reach WIDTH for MUL

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_NOT = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_EQ  = 4'd6;
  localparam logic [3:0] OP_NEQ = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8;
`ifdef ITER_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd9;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sh_q, f_q;
  logic [3:0]       sel_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q, br_q;

  logic [WIDTH-1:0] res_d, add_w, sub_w;
  logic             ovf_d, br_d;

`ifdef ITER_ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] acc_d;

  // One shift-add step: conditionally add A into the upper half, then shift the product right.
  always_comb begin
    mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_d     = {mul_sum_d, acc_q[WIDTH-1:1]};
  end
`endif

  // Final result and flags for the latched op; only consumed when the RUN counter reaches zero.
  always_comb begin
    add_w = a_q + b_q;
    sub_w = a_q - b_q;
    res_d = '0;
    ovf_d = 1'b0;
    br_d  = 1'b0;
    case (sel_q)
      OP_ADD: begin
        res_d = add_w;
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_NOT: res_d = ~b_q;
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_SHR, OP_SHL: res_d = sh_q;
      OP_EQ: begin
        res_d = WIDTH'(a_q == b_q);
        br_d  = (a_q == b_q);
      end
      OP_NEQ: begin
        res_d = WIDTH'(a_q != b_q);
        br_d  = (a_q != b_q);
      end
      OP_SUB: begin
        res_d = sub_w;
        ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
`ifdef ITER_ALU_MUL_EN
      OP_MUL: begin
        res_d = acc_q[WIDTH-1:0];
        ovf_d = |acc_q[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;  // illegal opcodes complete with zero result and flags
    endcase
  end

  // Control FSM and datapath: capture on accepted start, iterate in RUN, publish result on RUN->DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      f_q     <= '0;
      ovf_q   <= 1'b0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sel_q   <= bus.sel;
            sh_q    <= bus.a;
            state_q <= S_RUN;
            if (bus.sel == OP_SHR || bus.sel == OP_SHL) begin
              cnt_q <= {1'b0, bus.b[SHW-1:0]};
`ifdef ITER_ALU_MUL_EN
            end else if (bus.sel == OP_MUL) begin
              cnt_q <= CW'(WIDTH);
`endif
            end else begin
              cnt_q <= '0;
            end
`ifdef ITER_ALU_MUL_EN
            acc_q <= {{WIDTH{1'b0}}, bus.b};
`endif
          end
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            f_q     <= res_d;
            ovf_q   <= ovf_d;
            br_q    <= br_d;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            // sh_q is don't-care for non-shift ops, so it is stepped unconditionally
            if (sel_q == OP_SHR) begin
              sh_q <= sh_q >> 1;
            end else begin
              sh_q <= sh_q << 1;
            end
`ifdef ITER_ALU_MUL_EN
            acc_q <= acc_d;
`endif
          end
        end
        default: state_q <= S_IDLE;  // DONE lasts exactly one cycle
      endcase
    end
  end

  assign bus.f           = f_q;
  assign bus.ovf         = ovf_q;
  assign bus.take_branch = br_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu at WIDTH=8; expectations follow ITER_ALU_MUL_EN like the DUT build.
// Latency is measured from the cycle start is driven to the cycle done is seen.
// Driver waits for each op to retire before issuing the next.
module tb_iter_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [7:0] f;
    logic       ovf;
    logic       br;
    int         lat;
    int         t0;
  } exp_t;

  exp_t sb[$];

  iter_alu_if #(.WIDTH(8)) bus ();

  iter_alu #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Independent reference model for WIDTH=8.
  task automatic model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] f, output logic ov, output logic br, output int lat);
    int sa, sb_i, r, n;
    sa   = int'($signed(a));
    sb_i = int'($signed(b));
    n    = int'(b[2:0]);
    f = 8'h00; ov = 1'b0; br = 1'b0; lat = 2;
    case (s)
      4'd0: begin r = sa + sb_i; f = 8'(a + b); ov = (r > 127) || (r < -128); end
      4'd1: f = ~b;
      4'd2: f = a & b;
      4'd3: f = a | b;
      4'd4: begin f = a >> n; lat = n + 2; end
      4'd5: begin f = a << n; lat = n + 2; end
      4'd6: begin br = (a == b); f = {7'd0, br}; end
      4'd7: begin br = (a != b); f = {7'd0, br}; end
      4'd8: begin r = sa - sb_i; f = 8'(a - b); ov = (r > 127) || (r < -128); end
`ifdef ITER_ALU_MUL_EN
      4'd9: begin r = int'(a) * int'(b); f = r[7:0]; ov = (r > 255); lat = 10; end
`endif
      default: ;
    endcase
  endtask

  // Output side of the scoreboard: every done pulse retires the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", bus.done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("f", bus.f, e.f);
        check("ovf", bus.ovf, e.ovf);
        check("take_branch", bus.take_branch, e.br);
        check("latency", cyc - e.t0, e.lat);
      end
    end
  end

  // Called just after a falling edge; returns just after the falling edge following DONE.
  task automatic run_op(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ef, input logic eo, input logic eb, input int el,
                        input bit poke);
    exp_t e;
    e.f = ef; e.ovf = eo; e.br = eb; e.lat = el; e.t0 = cyc;
    sb.push_back(e);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.sel = s;
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.sel = 4'($urandom);
    if (poke) begin
      check("busy_run", bus.busy, 1'b1);
      bus.start = 1'b1;
      @(negedge clk); #1;
      bus.start = 1'b0;
      check("busy_run2", bus.busy, 1'b1);
    end
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk); #1;
    check("idle_busy", bus.busy, 1'b0);
    check("done_one_cycle", bus.done, 1'b0);
  endtask

  task automatic run_model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] f;
    logic       ov, br;
    int         lat;
    model(s, a, b, f, ov, br, lat);
    run_op(s, a, b, f, ov, br, lat, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.sel = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_f", bus.f, 8'h00);
    check("rst_ovf", bus.ovf, 1'b0);
    check("rst_br", bus.take_branch, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    reset = 1'b0;

    // Directed cases
    run_op(4'd0, 8'hD5, 8'hAA, 8'h7F, 1'b1, 1'b0, 2, 1'b0);
    run_op(4'd8, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 2, 1'b0);
    run_op(4'd8, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 2, 1'b0);
    run_op(4'd5, 8'h9A, 8'h03, 8'hD0, 1'b0, 1'b0, 5, 1'b1);
    run_op(4'd4, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 2, 1'b0);
    run_op(4'd6, 8'hA5, 8'hA5, 8'h01, 1'b0, 1'b1, 2, 1'b0);
    run_op(4'd7, 8'hC6, 8'hBA, 8'h01, 1'b0, 1'b1, 2, 1'b0);
    run_op(4'd1, 8'h00, 8'h3C, 8'hC3, 1'b0, 1'b0, 2, 1'b0);
    run_op(4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 2, 1'b0);
    run_op(4'd3, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 2, 1'b0);
    run_op(4'd4, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 9, 1'b0);
`ifdef ITER_ALU_MUL_EN
    run_op(4'd9, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 10, 1'b0);
    run_op(4'd9, 8'h0F, 8'h03, 8'h2D, 1'b0, 1'b0, 10, 1'b0);
`else
    run_op(4'd9, 8'h10, 8'h11, 8'h00, 1'b0, 1'b0, 2, 1'b0);
`endif
    run_op(4'd12, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 2, 1'b0);
    run_op(4'd7, 8'h11, 8'h22, 8'h01, 1'b0, 1'b1, 2, 1'b0);

    // Reset mid-SHL: op abandoned, outputs cleared, no done
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h07; bus.sel = 4'd5;
    @(negedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_f", bus.f, 8'h00);
    check("rst_mid_br", bus.take_branch, 1'b0);
    check("rst_mid_done", bus.done, 1'b0);
    reset = 1'b0;
    run_op(4'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 2, 1'b0);

    // Model-driven random ops
    for (int k = 0; k < 24; k++) begin
      run_model(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
